register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the 4x16 single-write register file.
- Configurable width and depth; two read ports; two write ports (port 1: ALU writeback, port 2: load writeback).
- Optional hardwired zero register and optional same-cycle write-to-read bypass.
- Per-register busy (scoreboard) bits so the decode stage can stall on pending producers. Sits between decode and writeback.

Parameters:
- DATA_W, 16, width of each register and of every data port.
- ADDR_W, 2, index width; depth = 2**ADDR_W registers.
- ZERO_REG, 0, if 1, register 0 always reads 0, and writes and reservations to it are ignored.
- BYPASS, 1, if 1, a write in progress is forwarded combinationally to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_index1  in  ADDR_W  read port 1 index.
- rd_index2  in  ADDR_W  read port 2 index.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- rd_busy1  out  1  busy bit of rd_index1, combinational.
- rd_busy2  out  1  busy bit of rd_index2, combinational.
- wr_enable  in  1  write port 1 enable.
- wr_index  in  ADDR_W  write port 1 index.
- wr_data  in  DATA_W  write port 1 data.
- wr2_enable  in  1  write port 2 enable.
- wr2_index  in  ADDR_W  write port 2 index.
- wr2_data  in  DATA_W  write port 2 data.
- rsv_enable  in  1  reserve: mark a register pending.
- rsv_index  in  ADDR_W  register to reserve.
- busy_vec  out  2**ADDR_W  all busy bits, registered.

Behaviour:
- Reset: on a rising edge with rst=1, all registers are set to 0 and busy_vec to 0. Writes and reservations in that cycle are discarded.
  - While rst=1, bypass is suppressed; reads return stored contents.
  - From the edge after reset: rd_data* = 0, rd_busy* = 0, busy_vec = 0.
- Write:
  - On a rising edge with rst=0, an enabled port stores its data at its index.
  - Both ports enabled with the same index: port 2 wins; the port 1 data is dropped.
  - Different indices: both store.
- Read:
  - rd_dataN is the stored register content, zero-latency combinational.
  - With BYPASS=1 and rst=0, the read returns the write data of any enabled port whose index matches rd_indexN, in the same cycle. Port 2 has priority over port 1, matching storage priority.
  - With BYPASS=0, new data is visible from the cycle after the edge.
- Zero register: with ZERO_REG=1, index 0 reads 0 on both read ports regardless of bypass. Writes and reservations to index 0 have no effect, and busy bit 0 is held at 0.
- Scoreboard:
  - On a rising edge with rst=0, each enabled write port clears busy[index].
  - rsv_enable sets busy[rsv_index].
  - Reserve and write to the same index in the same cycle: reserve wins and busy stays 1, because the newer producer is still outstanding.
  - Reserve of an already-busy register leaves it busy (no counting).
  - Write to a non-busy register is legal; busy stays 0.
- rd_busyN:
  - With BYPASS=1, rd_busyN = busy[rd_indexN] AND NOT (an enabled write port targets rd_indexN this cycle). This lets decode consume forwarded data without a stall.
  - With BYPASS=0, rd_busyN = busy[rd_indexN].
- Both read ports may address the same register; both return identical data and busy.
- Index arithmetic: no wrap concerns; every ADDR_W value is a valid register.

Test Plan:
- Reset then read:
  - Stimulus: assert rst for one edge with wr_enable=1, wr_index=1, wr_data=16'hBEEF.
  - Required: after the edge, all four registers read 16'h0000 and busy_vec=4'b0000.
- Dual write, distinct indices:
  - Stimulus: port 1 writes 16'h1234 to r2; port 2 writes 16'hABCD to r3 in the same cycle.
  - Required: next cycle, rd_index1=2 gives 16'h1234 and rd_index2=3 gives 16'hABCD.
- Write collision:
  - Stimulus: both ports target r1, with 16'h1111 on port 1 and 16'h2222 on port 2.
  - Required: same-cycle bypass read of r1 = 16'h2222 (BYPASS=1); stored value after the edge = 16'h2222.
- Scoreboard:
  - Stimulus: reserve r3; next cycle read r3 with no write active; then write r3 = 16'h00FF.
  - Required: busy_vec=4'b1000 and rd_busy1=1 while pending; in the write cycle rd_busy1=0 and rd_data1=16'h00FF; busy_vec=4'b0000 after the edge.
- Reserve/write race:
  - Stimulus: r2 is busy; in one cycle, write r2 = 16'h0042 and reserve r2.
  - Required: after the edge, r2 = 16'h0042 and busy[2]=1.
- ZERO_REG=1, BYPASS=0:
  - Stimulus: write 16'hFFFF to r0; reserve r0; write 16'h5555 to r1.
  - Required: r0 reads 16'h0000 and busy[0]=0. r1 reads its old value in the write cycle and 16'h5555 on the following cycle.

Source files
------------

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Purpose  : Parametrised multi-port register file sitting between decode and
//            writeback. Two combinational read ports, two write ports
//            (port 1 = ALU writeback, port 2 = load writeback, port 2 wins on
//            collision), optional hardwired zero register, optional
//            same-cycle write-to-read bypass, and a per-register busy
//            scoreboard so decode can stall on outstanding producers.
// Ports    : clk, rst (sync, active-high)
//            rd_index1/2 -> rd_data1/2, rd_busy1/2 (combinational)
//            wr_enable/wr_index/wr_data     (write port 1)
//            wr2_enable/wr2_index/wr2_data  (write port 2)
//            rsv_enable/rsv_index           (mark register pending)
//            busy_vec                       (registered busy bits)
// Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      rd_index1,
   input  logic [ADDR_W-1:0]      rd_index2,
   output logic [DATA_W-1:0]      rd_data1,
   output logic [DATA_W-1:0]      rd_data2,
   output logic                   rd_busy1,
   output logic                   rd_busy2,
   input  logic                   wr_enable,
   input  logic [ADDR_W-1:0]      wr_index,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   wr2_enable,
   input  logic [ADDR_W-1:0]      wr2_index,
   input  logic [DATA_W-1:0]      wr2_data,
   input  logic                   rsv_enable,
   input  logic [ADDR_W-1:0]      rsv_index,
   output logic [(2**ADDR_W)-1:0] busy_vec
);

   localparam int   DEPTH   = 2**ADDR_W;
   localparam logic HAS_ZERO = (ZERO_REG != 0);
   localparam logic HAS_BYP  = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;

   // Effective enables: with a hardwired zero register, anything aimed at
   // index 0 is simply dropped.
   logic wr1_ok, wr2_ok, rsv_ok;

   always_comb begin
      wr1_ok = wr_enable  && !(HAS_ZERO && (wr_index  == '0));
      wr2_ok = wr2_enable && !(HAS_ZERO && (wr2_index == '0));
      rsv_ok = rsv_enable && !(HAS_ZERO && (rsv_index == '0));
   end

   // Next-state: port 1 first, then port 2 so port 2 overrides on a shared
   // index; reservation last so a newer producer keeps the register busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = '0;
         end
         busy_d = '0;
      end else begin
         if (wr1_ok) begin
            regs_d[wr_index] = wr_data;
            busy_d[wr_index] = 1'b0;
         end
         if (wr2_ok) begin
            regs_d[wr2_index] = wr2_data;
            busy_d[wr2_index] = 1'b0;
         end
         if (rsv_ok) begin
            busy_d[rsv_index] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
      busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

   // Both read ports share identical logic; gather them into arrays so a
   // single generate body serves each.
   logic [ADDR_W-1:0] rd_idx  [2];
   logic [DATA_W-1:0] rd_dat  [2];
   logic              rd_bsy  [2];

   assign rd_idx[0] = rd_index1;
   assign rd_idx[1] = rd_index2;
   assign rd_data1  = rd_dat[0];
   assign rd_data2  = rd_dat[1];
   assign rd_busy1  = rd_bsy[0];
   assign rd_busy2  = rd_bsy[1];

   for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic hit1, hit2;
      always_comb begin
         // Forwarding is disabled while reset is held so reads see storage.
         hit1 = HAS_BYP && !rst && wr_enable  && (wr_index  == rd_idx[p]);
         hit2 = HAS_BYP && !rst && wr2_enable && (wr2_index == rd_idx[p]);

         if (HAS_ZERO && (rd_idx[p] == '0)) begin
            rd_dat[p] = '0;
         end else if (hit2) begin
            rd_dat[p] = wr2_data;
         end else if (hit1) begin
            rd_dat[p] = wr_data;
         end else begin
            rd_dat[p] = regs_q[rd_idx[p]];
         end

         // A producer writing this cycle satisfies the pending dependency,
         // so decode may consume the forwarded value without stalling.
         rd_bsy[p] = busy_q[rd_idx[p]] && !(hit1 || hit2);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_mp
// Purpose  : Self-checking bench for register_file_mp. Two instances share the
//            stimulus: u_dut0 (ZERO_REG=0, BYPASS=1) and u_dut1 (ZERO_REG=1,
//            BYPASS=0). A behavioural array model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rd_index1, rd_index2;
   logic        wr_enable, wr2_enable, rsv_enable;
   logic [1:0]  wr_index, wr2_index, rsv_index;
   logic [15:0] wr_data, wr2_data;

   logic [15:0] d0_rd1, d0_rd2, d1_rd1, d1_rd2;
   logic        d0_b1, d0_b2, d1_b1, d1_b2;
   logic [3:0]  d0_bv, d1_bv;

   int checks   = 0;
   int failures = 0;

   // Reference state: [config][register]
   logic [15:0] m_reg  [2][4];
   logic        m_busy [2][4];

   always #5 clk = ~clk;

   register_file_mp #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
      .clk(clk), .rst(rst),
      .rd_index1(rd_index1), .rd_index2(rd_index2),
      .rd_data1(d0_rd1), .rd_data2(d0_rd2),
      .rd_busy1(d0_b1), .rd_busy2(d0_b2),
      .wr_enable(wr_enable), .wr_index(wr_index), .wr_data(wr_data),
      .wr2_enable(wr2_enable), .wr2_index(wr2_index), .wr2_data(wr2_data),
      .rsv_enable(rsv_enable), .rsv_index(rsv_index),
      .busy_vec(d0_bv)
   );

   register_file_mp #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
      .clk(clk), .rst(rst),
      .rd_index1(rd_index1), .rd_index2(rd_index2),
      .rd_data1(d1_rd1), .rd_data2(d1_rd2),
      .rd_busy1(d1_b1), .rd_busy2(d1_b2),
      .wr_enable(wr_enable), .wr_index(wr_index), .wr_data(wr_data),
      .wr2_enable(wr2_enable), .wr2_index(wr2_index), .wr2_data(wr2_data),
      .rsv_enable(rsv_enable), .rsv_index(rsv_index),
      .busy_vec(d1_bv)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value: zero register first, then same-cycle forwarding
   // (load port before ALU port), otherwise stored contents.
   function automatic logic [15:0] exp_data(input int cfg, input logic [1:0] idx);
      bit zero = (cfg == 1);
      bit byp  = (cfg == 0);
      if (zero && idx == 2'd0) return 16'h0000;
      if (byp && !rst && wr2_enable && wr2_index == idx) return wr2_data;
      if (byp && !rst && wr_enable  && wr_index  == idx) return wr_data;
      return m_reg[cfg][idx];
   endfunction

   function automatic logic exp_busy(input int cfg, input logic [1:0] idx);
      bit byp = (cfg == 0);
      bit hit = (wr_enable && wr_index == idx) || (wr2_enable && wr2_index == idx);
      if (byp && !rst && hit) return 1'b0;
      return m_busy[cfg][idx];
   endfunction

   function automatic logic [3:0] exp_vec(input int cfg);
      return {m_busy[cfg][3], m_busy[cfg][2], m_busy[cfg][1], m_busy[cfg][0]};
   endfunction

   // Mid-cycle: compare all combinational outputs of both instances.
   task automatic settle();
      #3;
      chk("d0_rd_data1", d0_rd1, exp_data(0, rd_index1));
      chk("d0_rd_data2", d0_rd2, exp_data(0, rd_index2));
      chk("d0_rd_busy1", d0_b1,  exp_busy(0, rd_index1));
      chk("d0_rd_busy2", d0_b2,  exp_busy(0, rd_index2));
      chk("d1_rd_data1", d1_rd1, exp_data(1, rd_index1));
      chk("d1_rd_data2", d1_rd2, exp_data(1, rd_index2));
      chk("d1_rd_busy1", d1_b1,  exp_busy(1, rd_index1));
      chk("d1_rd_busy2", d1_b2,  exp_busy(1, rd_index2));
   endtask

   // Clock edge: advance the model from the sampled inputs, then check the
   // registered busy vector just after the edge.
   task automatic edge_step();
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            for (int r = 0; r < 4; r++) begin
               m_reg[c][r]  = 16'h0000;
               m_busy[c][r] = 1'b0;
            end
         end else begin
            if (wr_enable && !(c == 1 && wr_index == 2'd0)) begin
               m_reg[c][wr_index]  = wr_data;
               m_busy[c][wr_index] = 1'b0;
            end
            if (wr2_enable && !(c == 1 && wr2_index == 2'd0)) begin
               m_reg[c][wr2_index]  = wr2_data;
               m_busy[c][wr2_index] = 1'b0;
            end
            if (rsv_enable && !(c == 1 && rsv_index == 2'd0))
               m_busy[c][rsv_index] = 1'b1;
         end
      end
      #1;
      chk("d0_busy_vec", d0_bv, exp_vec(0));
      chk("d1_busy_vec", d1_bv, exp_vec(1));
   endtask

   task automatic idle(input logic [1:0] r1, input logic [1:0] r2);
      rst = 1'b0; wr_enable = 1'b0; wr2_enable = 1'b0; rsv_enable = 1'b0;
      rd_index1 = r1; rd_index2 = r2;
   endtask

   initial begin
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 4; r++) begin
            m_reg[c][r]  = 'x;
            m_busy[c][r] = 'x;
         end
      idle(2'd0, 2'd1);
      wr_index = 2'd0; wr2_index = 2'd0; rsv_index = 2'd0;
      wr_data = 16'h0; wr2_data = 16'h0;

      // Reset with a write and a reservation that must be discarded.
      rst = 1'b1; wr_enable = 1'b1; wr_index = 2'd1; wr_data = 16'hBEEF;
      rsv_enable = 1'b1; rsv_index = 2'd2;
      @(posedge clk); edge_step();   // first edge initialises, second is checked
      chk("reset_busy_vec", d0_bv, 4'b0000);

      idle(2'd0, 2'd1); settle();
      chk("reset_r0", d0_rd1, 16'h0000);
      chk("reset_r1", d0_rd2, 16'h0000);
      edge_step();
      idle(2'd2, 2'd3); settle();
      chk("reset_r2", d0_rd1, 16'h0000);
      chk("reset_r3", d0_rd2, 16'h0000);
      edge_step();

      // Dual write to distinct registers.
      idle(2'd0, 2'd0);
      wr_enable = 1'b1;  wr_index = 2'd2;  wr_data = 16'h1234;
      wr2_enable = 1'b1; wr2_index = 2'd3; wr2_data = 16'hABCD;
      settle(); edge_step();
      idle(2'd2, 2'd3); settle();
      chk("dual_r2", d0_rd1, 16'h1234);
      chk("dual_r3", d0_rd2, 16'hABCD);
      edge_step();

      // Collision on r1: load port wins both forwarding and storage.
      idle(2'd1, 2'd1);
      wr_enable = 1'b1;  wr_index = 2'd1;  wr_data = 16'h1111;
      wr2_enable = 1'b1; wr2_index = 2'd1; wr2_data = 16'h2222;
      settle();
      chk("collide_bypass", d0_rd1, 16'h2222);
      edge_step();
      idle(2'd1, 2'd0); settle();
      chk("collide_stored", d0_rd1, 16'h2222);
      edge_step();

      // Scoreboard on r3.
      idle(2'd3, 2'd3);
      rsv_enable = 1'b1; rsv_index = 2'd3;
      settle(); edge_step();
      idle(2'd3, 2'd0); settle();
      chk("sb_pending_vec", d0_bv, 4'b1000);
      chk("sb_pending_busy", d0_b1, 1'b1);
      edge_step();
      idle(2'd3, 2'd0);
      wr_enable = 1'b1; wr_index = 2'd3; wr_data = 16'h00FF;
      settle();
      chk("sb_write_busy", d0_b1, 1'b0);
      chk("sb_write_data", d0_rd1, 16'h00FF);
      edge_step();
      chk("sb_cleared_vec", d0_bv, 4'b0000);

      // Reserve/write race on r2.
      idle(2'd2, 2'd0);
      rsv_enable = 1'b1; rsv_index = 2'd2;
      settle(); edge_step();
      idle(2'd2, 2'd0);
      wr_enable = 1'b1; wr_index = 2'd2; wr_data = 16'h0042;
      rsv_enable = 1'b1; rsv_index = 2'd2;
      settle(); edge_step();
      chk("race_busy2", d0_bv[2], 1'b1);
      idle(2'd2, 2'd0); settle();
      chk("race_r2", d0_rd1, 16'h0042);
      edge_step();

      // Zero register and no-bypass behaviour on the second instance.
      idle(2'd0, 2'd0);
      wr_enable = 1'b1; wr_index = 2'd0; wr_data = 16'hFFFF;
      settle(); edge_step();
      idle(2'd0, 2'd0);
      rsv_enable = 1'b1; rsv_index = 2'd0;
      settle(); edge_step();
      chk("zero_busy0", d1_bv[0], 1'b0);
      idle(2'd0, 2'd1);
      wr_enable = 1'b1; wr_index = 2'd1; wr_data = 16'h5555;
      settle();
      chk("zero_r0", d1_rd1, 16'h0000);
      chk("nobyp_old_r1", d1_rd2, 16'h2222);
      edge_step();
      idle(2'd1, 2'd0); settle();
      chk("nobyp_new_r1", d1_rd1, 16'h5555);
      chk("zero_r0_again", d1_rd2, 16'h0000);
      edge_step();

      // Randomised traffic with occasional reset.
      for (int n = 0; n < 300; n++) begin
         rst        = ($urandom_range(0, 31) == 0);
         rd_index1  = 2'($urandom_range(0, 3));
         rd_index2  = 2'($urandom_range(0, 3));
         wr_enable  = 1'($urandom_range(0, 1));
         wr_index   = 2'($urandom_range(0, 3));
         wr_data    = 16'($urandom);
         wr2_enable = 1'($urandom_range(0, 1));
         wr2_index  = 2'($urandom_range(0, 3));
         wr2_data   = 16'($urandom);
         rsv_enable = 1'($urandom_range(0, 1));
         rsv_index  = 2'($urandom_range(0, 3));
         settle();
         edge_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
